sram_port_arbiter: RTL

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_port_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
// Two-master round-robin arbiter in front of a single SRAM controller port.
// m0 is the CPU data port, m1 is the DMA port. A grant is issued combinationally
// when the SRAM is available and ready; the response (read data or a zero for
// writes) is returned on the granted master's response port one cycle later.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   mX_req_valid/ready       request handshake (ready = grant this cycle)
//   mX_we/be/addr/wdata      request payload
//   mX_rsp_valid/rdata/err   one-cycle response strobe, data, error flag
//   sram_req/we/be/addr/wdata  access port to the SRAM controller
//   sram_rdata               combinational read data from the controller
//   sram_ready, sram_avail   controller ready / SRAM usable
//
// Optional feature macro: SRAM_ARB_ALIGN_CHECK_EN
//   defined   : requests with addr[1:0] != 0 are accepted but not forwarded to
//               the SRAM; they complete with rsp_err=1 and rsp_rdata=0.
//   undefined : no alignment check, rsp_err is always 0.
// -----------------------------------------------------------------------------
module sram_port_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req_valid,
    output logic        m0_req_ready,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    input  logic [12:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_rsp_valid,
    output logic [31:0] m0_rsp_rdata,
    output logic        m0_rsp_err,
    input  logic        m1_req_valid,
    output logic        m1_req_ready,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [12:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_rsp_valid,
    output logic [31:0] m1_rsp_rdata,
    output logic        m1_rsp_err,
    output logic        sram_req,
    output logic        sram_we,
    output logic [3:0]  sram_be,
    output logic [12:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    input  logic        sram_ready,
    input  logic        sram_avail
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 13;
    localparam int unsigned BE_W   = 4;

    // Priority pointer: 0 = m0 has priority, 1 = m1 has priority
    logic              ptr_q, ptr_d;
    logic              grant_ok_c, gnt0_c, gnt1_c, misal_c, issue_c;
    logic              sel_we_c;
    logic [BE_W-1:0]   sel_be_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_wdata_c;

    logic              rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
    logic [DATA_W-1:0] rsp0_rdata_q, rsp0_rdata_d, rsp1_rdata_q, rsp1_rdata_d;
    logic              rsp0_err_q, rsp0_err_d, rsp1_err_q, rsp1_err_d;

    // Grant decision; reset also blocks grants so nothing is owed across it
    assign grant_ok_c = sram_avail & sram_ready & ~rst;
    assign gnt0_c     = grant_ok_c & m0_req_valid & (~m1_req_valid | ~ptr_q);
    assign gnt1_c     = grant_ok_c & m1_req_valid & (~m0_req_valid |  ptr_q);

    assign m0_req_ready = gnt0_c;
    assign m1_req_ready = gnt1_c;

    // Mux of the granted master's request (gnt0/gnt1 are mutually exclusive)
    always_comb begin
        sel_we_c    = 1'b0;
        sel_be_c    = '0;
        sel_addr_c  = '0;
        sel_wdata_c = '0;
        if (gnt0_c) begin
            sel_we_c    = m0_we;
            sel_be_c    = m0_be;
            sel_addr_c  = m0_addr;
            sel_wdata_c = m0_wdata;
        end else if (gnt1_c) begin
            sel_we_c    = m1_we;
            sel_be_c    = m1_be;
            sel_addr_c  = m1_addr;
            sel_wdata_c = m1_wdata;
        end
    end

`ifdef SRAM_ARB_ALIGN_CHECK_EN
    assign misal_c = (gnt0_c | gnt1_c) & (sel_addr_c[1:0] != 2'b00);
`else
    assign misal_c = 1'b0;
`endif

    // Misaligned grants complete on the master side without touching the SRAM
    assign issue_c    = (gnt0_c | gnt1_c) & ~misal_c;
    assign sram_req   = issue_c;
    assign sram_we    = issue_c & sel_we_c;
    assign sram_be    = issue_c ? sel_be_c    : '0;
    assign sram_addr  = issue_c ? sel_addr_c  : '0;
    assign sram_wdata = issue_c ? sel_wdata_c : '0;

    // Next-state: pointer rotation and response capture
    always_comb begin
        ptr_d        = ptr_q;
        rsp0_valid_d = gnt0_c;
        rsp1_valid_d = gnt1_c;
        rsp0_rdata_d = rsp0_rdata_q;
        rsp1_rdata_d = rsp1_rdata_q;
        rsp0_err_d   = gnt0_c & misal_c;
        rsp1_err_d   = gnt1_c & misal_c;
        if (gnt0_c) begin
            ptr_d        = 1'b1;
            rsp0_rdata_d = (m0_we | misal_c) ? '0 : sram_rdata;
        end else if (gnt1_c) begin
            ptr_d        = 1'b0;
            rsp1_rdata_d = (m1_we | misal_c) ? '0 : sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
            rsp0_err_q   <= 1'b0;
            rsp1_err_q   <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
            rsp0_err_q   <= rsp0_err_d;
            rsp1_err_q   <= rsp1_err_d;
        end
    end

    assign m0_rsp_valid = rsp0_valid_q;
    assign m0_rsp_rdata = rsp0_rdata_q;
    assign m0_rsp_err   = rsp0_err_q;
    assign m1_rsp_valid = rsp1_valid_q;
    assign m1_rsp_rdata = rsp1_rdata_q;
    assign m1_rsp_err   = rsp1_err_q;

endmodule
